serial_pe_writeback: RTL and testbench

- Downstream neighbour of the serial data loader: consumes its weight/feature byte stream, `acc_en` and `rst_pe`.
- Performs a signed serial MAC over one 3x3 window (9 taps) and captures the sum.
- Quantizes the sum, clamps it and writes it back to feature memory through a request/ready write port.
- Sits between the loader and the memory arbiter. The loader owns the read address; this block owns a separate write address.

---
 rtl/serial_pe_pkg.sv | 17 +
 rtl/serial_mac_unit.sv | 61 ++++++
 rtl/serial_pe_writeback.sv | 131 +++++++++++++
 tb/tb_serial_pe_writeback.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pe_pkg.sv
// Shared constants and write-FSM encoding for the serial PE writeback slice.
package serial_pe_pkg;

    localparam int NUM_TAPS = 9;
    localparam int ACC_W    = 20;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 6;

    localparam int QMAX = 127;
    localparam int QMIN = -128;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } wb_state_e;

endpackage

// File: rtl/serial_mac_unit.sv
// Signed serial MAC over one window: accumulator, tap counter and capture register.
module serial_mac_unit
    import serial_pe_pkg::*;
#(
    parameter int TAPS  = NUM_TAPS,
    parameter int SUM_W = ACC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] w_in,
    input  logic signed [DATA_W-1:0] f_in,
    input  logic                     acc_en,
    input  logic                     rst_pe,
    input  logic                     hold_result,
    output logic                     capture,
    output logic signed [SUM_W-1:0]  result
);

    localparam int CNT_W  = $clog2(TAPS + 1);
    localparam int PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] product;
    logic signed [SUM_W-1:0]  product_ext;
    logic signed [SUM_W-1:0]  acc;
    logic signed [SUM_W-1:0]  sum;
    logic [CNT_W-1:0]         tap_cnt;
    logic                     last_tap;

    assign product     = w_in * f_in;
    assign product_ext = {{(SUM_W - PROD_W){product[PROD_W-1]}}, product};
    assign sum         = acc + product_ext;
    assign last_tap    = (tap_cnt == CNT_W'(TAPS - 1));

    // rst_pe overrides acc_en, so a tap presented alongside it never completes a window
    assign capture = acc_en && !rst_pe && last_tap;

    always_ff @(posedge clk) begin
        if (rst || rst_pe) begin
            acc     <= '0;
            tap_cnt <= '0;
        end else if (acc_en) begin
            if (last_tap) begin
                acc     <= '0;
                tap_cnt <= '0;
            end else begin
                acc     <= sum;
                tap_cnt <= tap_cnt + CNT_W'(1);
            end
        end
    end

    // hold_result keeps a pending write's value when a new window finishes too early
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
        end else if (capture && !hold_result) begin
            result <= sum;
        end
    end

endmodule

// File: rtl/serial_pe_writeback.sv
// Quantizes each captured MAC sum and writes it to feature memory over a request/ready port.
module serial_pe_writeback
    import serial_pe_pkg::*;
#(
    parameter int NUM_TAPS = serial_pe_pkg::NUM_TAPS,
    parameter int ACC_W    = serial_pe_pkg::ACC_W,
    parameter int SHIFT    = 0,
    parameter int RELU     = 1,
    parameter int NUM_OUT  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] w_in,
    input  logic signed [DATA_W-1:0] f_in,
    input  logic                     acc_en,
    input  logic                     rst_pe,
    input  logic [7:0]               result_baseaddr,
    input  logic                     wr_ready,
    output logic                     we,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic                     layer_done,
    output logic                     overrun
);

    localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);

    localparam logic signed [ACC_W-1:0] Q_HI = ACC_W'(QMAX);
    localparam logic signed [ACC_W-1:0] Q_LO = (RELU != 0) ? '0 : ACC_W'(QMIN);

    wb_state_e               state;
    wb_state_e               state_next;
    logic [IDX_W-1:0]        out_idx;
    logic                    capture;
    logic                    hold_result;
    logic                    write_done;
    logic                    drop;
    logic signed [ACC_W-1:0] result;
    logic signed [ACC_W-1:0] shifted;
    logic [7:0]              addr_full;
    logic [1:0]              addr_unused;

    assign hold_result = (state == PEND) && !wr_ready;

    serial_mac_unit #(
        .TAPS  (NUM_TAPS),
        .SUM_W (ACC_W)
    ) u_mac (
        .clk         (clk),
        .rst         (rst),
        .w_in        (w_in),
        .f_in        (f_in),
        .acc_en      (acc_en),
        .rst_pe      (rst_pe),
        .hold_result (hold_result),
        .capture     (capture),
        .result      (result)
    );

    assign shifted = result >>> SHIFT;

    always_comb begin
        if (shifted > Q_HI) begin
            wr_data = Q_HI[DATA_W-1:0];
        end else if (shifted < Q_LO) begin
            wr_data = Q_LO[DATA_W-1:0];
        end else begin
            wr_data = shifted[DATA_W-1:0];
        end
    end

    // Output region wraps modulo 64; the high bits of the 8-bit sum are intentionally discarded
    assign addr_full   = result_baseaddr + 8'(out_idx);
    assign wr_addr     = addr_full[ADDR_W-1:0];
    assign addr_unused = addr_full[7:ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        we         = 1'b0;
        write_done = 1'b0;
        layer_done = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_next = PEND;
                end
            end
            PEND: begin
                we = 1'b1;
                if (wr_ready) begin
                    write_done = 1'b1;
                    layer_done = (out_idx == LAST_IDX);
                    // a capture landing on the completing cycle becomes the next pending write
                    if (!capture) begin
                        state_next = IDLE;
                    end
                end else if (capture) begin
                    drop = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_idx <= '0;
            overrun <= 1'b0;
        end else begin
            if (write_done) begin
                out_idx <= (out_idx == LAST_IDX) ? '0 : out_idx + IDX_W'(1);
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_pe_writeback.sv
// Scoreboard bench: three parameterisations share one stimulus stream and are checked against a model.
module tb_serial_pe_writeback;

    logic       clk;
    logic       rst;
    logic [7:0] w_in;
    logic [7:0] f_in;
    logic       acc_en;
    logic       rst_pe;
    logic [7:0] base;
    logic       wr_ready;

    logic [2:0]      we_o;
    logic [2:0]      ld_o;
    logic [2:0]      ovr_o;
    logic [2:0][5:0] addr_o;
    logic [2:0][7:0] data_o;

    typedef struct {
        logic [2:0][5:0] addr;
        logic [2:0][7:0] data;
        logic [2:0]      ld;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   idx[3];
    int   checks = 0;
    int   passes = 0;

    // dut0: defaults, dut1: signed clamp with short layer, dut2: heavy shift
    serial_pe_writeback #(.SHIFT(0), .RELU(1), .NUM_OUT(16)) dut0 (
        .clk(clk), .rst(rst), .w_in(w_in), .f_in(f_in), .acc_en(acc_en), .rst_pe(rst_pe),
        .result_baseaddr(base), .wr_ready(wr_ready), .we(we_o[0]), .wr_addr(addr_o[0]),
        .wr_data(data_o[0]), .layer_done(ld_o[0]), .overrun(ovr_o[0])
    );
    serial_pe_writeback #(.SHIFT(0), .RELU(0), .NUM_OUT(4)) dut1 (
        .clk(clk), .rst(rst), .w_in(w_in), .f_in(f_in), .acc_en(acc_en), .rst_pe(rst_pe),
        .result_baseaddr(base), .wr_ready(wr_ready), .we(we_o[1]), .wr_addr(addr_o[1]),
        .wr_data(data_o[1]), .layer_done(ld_o[1]), .overrun(ovr_o[1])
    );
    serial_pe_writeback #(.SHIFT(10), .RELU(1), .NUM_OUT(16)) dut2 (
        .clk(clk), .rst(rst), .w_in(w_in), .f_in(f_in), .acc_en(acc_en), .rst_pe(rst_pe),
        .result_baseaddr(base), .wr_ready(wr_ready), .we(we_o[2]), .wr_addr(addr_o[2]),
        .wr_data(data_o[2]), .layer_done(ld_o[2]), .overrun(ovr_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int p_shift(input int k);
        return (k == 2) ? 10 : 0;
    endfunction

    function automatic int p_relu(input int k);
        return (k == 1) ? 0 : 1;
    endfunction

    function automatic int p_numout(input int k);
        return (k == 1) ? 4 : 16;
    endfunction

    function automatic logic [7:0] quant(input int sum, input int sh, input int relu);
        int q;
        q = sum >>> sh;
        if (q > 127) q = 127;
        if (relu != 0 && q < 0) q = 0;
        if (q < -128) q = -128;
        return q[7:0];
    endfunction

    task automatic push_expect(input int sum);
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            e.addr[k] = 6'((int'(base) + idx[k]) % 64);
            e.data[k] = quant(sum, p_shift(k), p_relu(k));
            e.ld[k]   = (idx[k] == p_numout(k) - 1);
            idx[k]    = e.ld[k] ? 0 : idx[k] + 1;
        end
        exp_q.push_back(e);
    endtask

    task automatic run_group(input int w, input int f, input bit expect_write, input bit ready_on_last);
        for (int i = 0; i < 9; i++) begin
            w_in   = 8'(w);
            f_in   = 8'(f);
            acc_en = 1'b1;
            if (ready_on_last && i == 8) wr_ready = 1'b1;
            @(posedge clk); #1;
        end
        acc_en = 1'b0;
        if (expect_write) push_expect(9 * w * f);
    endtask

    // Every committed write is popped from the scoreboard and compared per instance
    always @(negedge clk) begin
        if (!rst && wr_ready && we_o[0]) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_write: got addr %0d data %h, expected no write", addr_o[0], data_o[0]);
            end else begin
                mon_e = exp_q.pop_front();
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (we_o[k] !== 1'b1 || addr_o[k] !== mon_e.addr[k])
                        $display("[TB] FAIL wr_addr inst%0d: got %0d (we %b), expected %0d", k, addr_o[k], we_o[k], mon_e.addr[k]);
                    else passes++;
                    checks++;
                    if (data_o[k] !== mon_e.data[k])
                        $display("[TB] FAIL wr_data inst%0d: got %h, expected %h", k, data_o[k], mon_e.data[k]);
                    else passes++;
                    checks++;
                    if (ld_o[k] !== mon_e.ld[k])
                        $display("[TB] FAIL layer_done inst%0d: got %b, expected %b", k, ld_o[k], mon_e.ld[k]);
                    else passes++;
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; acc_en = 1'b0; rst_pe = 1'b0; wr_ready = 1'b0;
        w_in = '0; f_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 3; k++) idx[k] = 0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (we_o[k] !== 1'b0 || data_o[k] !== 8'h00 || ld_o[k] !== 1'b0 || ovr_o[k] !== 1'b0)
                $display("[TB] FAIL reset inst%0d: got we %b data %h ld %b ovr %b, expected 0 0 0 0",
                         k, we_o[k], data_o[k], ld_o[k], ovr_o[k]);
            else passes++;
        end
    endtask

    task automatic test_single_write();
        base = 8'h10; wr_ready = 1'b1;
        run_group(2, 3, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (we_o !== 3'b111) $display("[TB] FAIL we_at_T+1: got %b, expected 111", we_o);
        else passes++;
        @(negedge clk);
        checks++;
        if (we_o !== 3'b000) $display("[TB] FAIL we_at_T+2: got %b, expected 000", we_o);
        else passes++;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) $display("[TB] FAIL single_drain: got %0d pending, expected 0", exp_q.size());
        else passes++;
    endtask

    task automatic test_clamp();
        base = 8'h20; wr_ready = 1'b1;
        run_group(-1, 100, 1'b1, 1'b0);
        run_group(127, 127, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) $display("[TB] FAIL clamp_drain: got %0d pending, expected 0", exp_q.size());
        else passes++;
    endtask

    task automatic test_back_to_back();
        base = 8'h05; wr_ready = 1'b0;
        run_group(2, 2, 1'b1, 1'b0);
        run_group(-3, 4, 1'b1, 1'b1);
        run_group(1, 5, 1'b1, 1'b0);
        run_group(2, 5, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) $display("[TB] FAIL b2b_drain: got %0d pending, expected 0", exp_q.size());
        else passes++;
        checks++;
        if (ovr_o !== 3'b000) $display("[TB] FAIL b2b_overrun: got %b, expected 000", ovr_o);
        else passes++;
    endtask

    task automatic test_overrun();
        base = 8'h30; wr_ready = 1'b0;
        run_group(3, 4, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (we_o !== 3'b111 || ovr_o !== 3'b000)
            $display("[TB] FAIL overrun_pending: got we %b ovr %b, expected 111 000", we_o, ovr_o);
        else passes++;
        run_group(5, 5, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (we_o !== 3'b111 || ovr_o !== 3'b111)
            $display("[TB] FAIL overrun_set: got we %b ovr %b, expected 111 111", we_o, ovr_o);
        else passes++;
        wr_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || we_o !== 3'b000)
            $display("[TB] FAIL overrun_drain: got %0d pending we %b, expected 0 000", exp_q.size(), we_o);
        else passes++;
        checks++;
        if (ovr_o !== 3'b111) $display("[TB] FAIL overrun_sticky: got %b, expected 111", ovr_o);
        else passes++;
    endtask

    task automatic test_rst_pe();
        base = 8'h08; wr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w_in = 8'd7; f_in = 8'd7; acc_en = 1'b1;
            @(posedge clk); #1;
        end
        w_in = 8'd100; f_in = 8'd100; rst_pe = 1'b1;
        @(posedge clk); #1;
        rst_pe = 1'b0; acc_en = 1'b0;
        @(negedge clk);
        checks++;
        if (we_o !== 3'b000) $display("[TB] FAIL partial_no_write: got we %b, expected 000", we_o);
        else passes++;
        run_group(1, 1, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) $display("[TB] FAIL rst_pe_drain: got %0d pending, expected 0", exp_q.size());
        else passes++;
    endtask

    task automatic test_reset_mid();
        base = 8'h11; wr_ready = 1'b0;
        run_group(9, 9, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (we_o !== 3'b111) $display("[TB] FAIL mid_pending: got we %b, expected 111", we_o);
        else passes++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) idx[k] = 0;
        @(negedge clk);
        checks++;
        if (we_o !== 3'b000 || data_o !== 24'h0) $display("[TB] FAIL mid_reset: got we %b data %h, expected 000 000000", we_o, data_o);
        else passes++;
        wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_addr_wrap();
        base = 8'd62; wr_ready = 1'b1;
        for (int g = 0; g < 5; g++) run_group(g + 1, 2, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) $display("[TB] FAIL wrap_drain: got %0d pending, expected 0", exp_q.size());
        else passes++;
    endtask

    initial begin
        base = '0;
        test_reset();
        test_single_write();
        test_clamp();
        test_back_to_back();
        test_overrun();
        test_reset();
        test_rst_pe();
        test_reset_mid();
        test_reset();
        test_addr_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
